dmem_arbiter: RTL and testbench

// - Shares the single-port byte-addressed data memory between two requesters:
//   the core memory-access (MA) stage and an auxiliary port used for loader/debug/DMA.
// - Each requester issues one access per grant, using funct3 size codes.
// - Fixed core priority with an anti-starvation counter.
// - Checks alignment and range, and returns read data one cycle after the grant.
// - Drives core_stall so the pipeline holds MA while the core waits.

---
 rtl/dmem_arbiter.sv | 143 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory: core MA stage vs. aux port.
// Define DMEM_ARB_RR_EN for round-robin arbitration instead of core priority with starvation limit.
module dmem_arbiter #(
    parameter int DEPTH        = 1000,
    parameter int AW           = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [2:0]    c_funct3,
    input  logic [AW-1:0] c_addr,
    input  logic [31:0]   c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [31:0]   c_rdata,
    output logic          c_err,
    output logic          core_stall,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [2:0]    a_funct3,
    input  logic [AW-1:0] a_addr,
    input  logic [31:0]   a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [31:0]   a_rdata,
    output logic          a_err,
    output logic          m_en,
    output logic          m_we,
    output logic [2:0]    m_funct3,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_wdata,
    input  logic [31:0]   m_rdata
);
    // state | meaning
    // IDLE  | no response outstanding
    // RESP  | load data or fault response presented this cycle to owner_q
    typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

    localparam logic          OWN_CORE = 1'b0;
    localparam logic          OWN_AUX  = 1'b1;
    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          err_q, err_d;
    logic          gnt, sel_aux, legal, aligned, sel_we, resp;
    logic [2:0]    sel_f3, size;
    logic [AW-1:0] sel_addr;
    logic [31:0]   sel_wdata;
    logic [AW:0]   end_addr;

`ifdef DMEM_ARB_RR_EN
    logic last_q;

    always_ff @(posedge clk) begin
        if (reset)
            last_q <= OWN_CORE;
        else if (gnt)
            last_q <= sel_aux;
    end

    // On conflict the port that did not win last time gets the memory.
    assign sel_aux = a_req & (~c_req | (last_q == OWN_CORE));
`else
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);
    logic [3:0] starve_q;

    always_ff @(posedge clk) begin
        if (reset)
            starve_q <= '0;
        else if (a_req & ~a_gnt)
            starve_q <= (starve_q == STARVE_LIM) ? starve_q : starve_q + 4'd1;
        else
            starve_q <= '0;
    end

    assign sel_aux = a_req & (~c_req | (starve_q == STARVE_LIM));
`endif

    assign gnt        = ~reset & (c_req | a_req);
    assign c_gnt      = gnt & ~sel_aux;
    assign a_gnt      = gnt & sel_aux;
    assign core_stall = ~reset & c_req & ~c_gnt;

    assign sel_we    = sel_aux ? a_we     : c_we;
    assign sel_f3    = sel_aux ? a_funct3 : c_funct3;
    assign sel_addr  = sel_aux ? a_addr   : c_addr;
    assign sel_wdata = sel_aux ? a_wdata  : c_wdata;

    always_comb begin
        size = 3'd0;
        case (sel_f3)
            3'b000, 3'b100: size = 3'd1;
            3'b001, 3'b101: size = 3'd2;
            3'b010:         size = 3'd4;
            default:        size = 3'd0;
        endcase
        aligned  = ~((size == 3'd2) & sel_addr[0]) & ~((size == 3'd4) & (sel_addr[1:0] != 2'b00));
        // One extra bit so an access running past the top cannot wrap back into range.
        end_addr = {1'b0, sel_addr} + (AW+1)'(size);
        legal    = (size != 3'd0) & aligned & (end_addr <= DEPTH_W);
    end

    assign m_en     = gnt & legal;
    assign m_we     = gnt & legal & sel_we;
    assign m_funct3 = gnt ? sel_f3    : 3'b000;
    assign m_addr   = gnt ? sel_addr  : '0;
    assign m_wdata  = gnt ? sel_wdata : 32'h0;

    always_comb begin
        state_d = IDLE;
        owner_d = owner_q;
        err_d   = 1'b0;
        if (gnt & (~legal | ~sel_we)) begin
            state_d = RESP;
            owner_d = sel_aux;
            err_d   = ~legal;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= OWN_CORE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            err_q   <= err_d;
        end
    end

    assign resp     = (state_q == RESP) & ~reset;
    assign c_rvalid = resp & (owner_q == OWN_CORE);
    assign a_rvalid = resp & (owner_q == OWN_AUX);
    assign c_err    = c_rvalid & err_q;
    assign a_err    = a_rvalid & err_q;
    assign c_rdata  = (c_rvalid & ~err_q) ? m_rdata : 32'h0;
    assign a_rdata  = (a_rvalid & ~err_q) ? m_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios then random dual-port traffic
// against a byte-array memory model and a behavioural arbitration model.
module tb_dmem_arbiter;
    localparam int DEPTH = 1000;
    localparam int AW    = 10;
    localparam int LIM   = 4;

    logic          clk = 1'b0, reset = 1'b1;
    logic          c_req = 1'b0, c_we = 1'b0, a_req = 1'b0, a_we = 1'b0;
    logic [2:0]    c_funct3 = '0, a_funct3 = '0;
    logic [AW-1:0] c_addr = '0, a_addr = '0;
    logic [31:0]   c_wdata = '0, a_wdata = '0, m_rdata = '0;
    logic          c_gnt, c_rvalid, c_err, core_stall, a_gnt, a_rvalid, a_err, m_en, m_we;
    logic [31:0]   c_rdata, a_rdata, m_wdata;
    logic [2:0]    m_funct3;
    logic [AW-1:0] m_addr;

    dmem_arbiter #(.DEPTH(DEPTH), .AW(AW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_funct3(c_funct3), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err), .core_stall(core_stall),
        .a_req(a_req), .a_we(a_we), .a_funct3(a_funct3), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
        .m_en(m_en), .m_we(m_we), .m_funct3(m_funct3), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { int due; logic err; logic [31:0] data; } resp_t;

    int          checks = 0, errors = 0, cyc = 0, aux_wait = 0;
    logic [7:0]  phys_mem [DEPTH];
    logic [7:0]  ref_mem  [DEPTH];
    resp_t       cq [$];
    resp_t       aq [$];
    logic        last_c_gnt = 1'b0, last_a_gnt = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit legal_f(input logic [2:0] f3, input int a);
        int sz;
        sz = size_of(f3);
        return (sz != 0) && (a % sz == 0) && (a + sz <= DEPTH);
    endfunction

    function automatic logic [31:0] ld(input bit from_ref, input int a, input logic [2:0] f3);
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++)
            b[i] = (a + i < DEPTH) ? (from_ref ? ref_mem[a+i] : phys_mem[a+i]) : 8'h00;
        case (f3)
            3'b000:  return {{24{b[0][7]}}, b[0]};
            3'b100:  return {24'h0, b[0]};
            3'b001:  return {{16{b[1][7]}}, b[1], b[0]};
            3'b101:  return {16'h0, b[1], b[0]};
            default: return {b[3], b[2], b[1], b[0]};
        endcase
    endfunction

    task automatic st(input bit to_ref, input int a, input logic [2:0] f3, input logic [31:0] d);
        int n;
        n = size_of(f3);
        for (int i = 0; i < n; i++)
            if (a + i < DEPTH) begin
                if (to_ref) ref_mem[a+i] = d[8*i +: 8];
                else        phys_mem[a+i] = d[8*i +: 8];
            end
    endtask

    // Memory device: reacts only to what the DUT actually drives on m_*.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (m_en && !m_we) m_rdata <= ld(1'b0, int'(m_addr), m_funct3);
        else               m_rdata <= $urandom;
        if (m_en && m_we) st(1'b0, int'(m_addr), m_funct3, m_wdata);
    end

    function automatic logic any_out();
        return c_gnt | c_rvalid | c_err | (|c_rdata) | core_stall | a_gnt | a_rvalid | a_err |
               (|a_rdata) | m_en | m_we | (|m_funct3) | (|m_addr) | (|m_wdata);
    endfunction

    // Grant-side model: predicts the winner and pushes the expected response.
    always @(negedge clk) begin
        bit ec, ea, lg, we;
        logic [2:0] f3;
        int ad;
        logic [31:0] wd;
        resp_t r;
        if (reset) begin
            cq.delete(); aq.delete();
            aux_wait = 0; last_c_gnt = 1'b0; last_a_gnt = 1'b0;
            chk("reset_outputs", any_out(), 0);
        end else begin
            ec = c_req && (!a_req || aux_wait != LIM);
            ea = a_req && !ec;
            chk("c_gnt", c_gnt, ec);
            chk("a_gnt", a_gnt, ea);
            chk("core_stall", core_stall, c_req && !ec);
            if (ec || ea) begin
                f3 = ec ? c_funct3 : a_funct3;
                ad = ec ? int'(c_addr) : int'(a_addr);
                we = ec ? c_we : a_we;
                wd = ec ? c_wdata : a_wdata;
                lg = legal_f(f3, ad);
                chk("m_en", m_en, lg);
                r.due = cyc + 1;
                if (!lg) begin
                    r.err = 1'b1; r.data = 32'h0;
                    if (ec) cq.push_back(r); else aq.push_back(r);
                end else begin
                    chk("m_we", m_we, we);
                    chk("m_addr", m_addr, ad);
                    chk("m_funct3", m_funct3, f3);
                    if (we) begin
                        chk("m_wdata", m_wdata, wd);
                        st(1'b1, ad, f3, wd);
                    end else begin
                        r.err = 1'b0; r.data = ld(1'b1, ad, f3);
                        if (ec) cq.push_back(r); else aq.push_back(r);
                    end
                end
            end else begin
                chk("m_en_idle", m_en, 0);
            end
            if (a_req && !ea) aux_wait = (aux_wait < LIM) ? aux_wait + 1 : LIM;
            else              aux_wait = 0;
            last_c_gnt = c_gnt;
            last_a_gnt = a_gnt;
        end
    end

    task automatic mon_port(input bit is_aux, input logic rv, input logic er, input logic [31:0] rd);
        resp_t r;
        int n;
        string nm;
        nm = is_aux ? "a" : "c";
        n  = is_aux ? aq.size() : cq.size();
        if (rv) begin
            chk({nm, "_rvalid_expected"}, (n > 0), 1);
            if (n > 0) begin
                if (is_aux) r = aq.pop_front(); else r = cq.pop_front();
                chk({nm, "_resp_cycle"}, cyc, r.due);
                chk({nm, "_err"}, er, r.err);
                chk({nm, "_rdata"}, rd, r.data);
            end
        end else begin
            chk({nm, "_quiet"}, er | (|rd), 0);
            if (n > 0) begin
                if (is_aux) r = aq[0]; else r = cq[0];
                if (r.due <= cyc) begin
                    chk({nm, "_rvalid_missing"}, rv, 1);
                    if (is_aux) void'(aq.pop_front()); else void'(cq.pop_front());
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            mon_port(1'b0, c_rvalid, c_err, c_rdata);
            mon_port(1'b1, a_rvalid, a_err, a_rdata);
        end
    end

    task automatic do_req(input bit aux, input logic we, input logic [2:0] f3, input int addr,
                          input logic [31:0] wd);
        bit got;
        @(posedge clk); #1;
        if (aux) begin a_req = 1; a_we = we; a_funct3 = f3; a_addr = AW'(addr); a_wdata = wd; end
        else     begin c_req = 1; c_we = we; c_funct3 = f3; c_addr = AW'(addr); c_wdata = wd; end
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = aux ? a_gnt : c_gnt;
        end
        chk("grant_timeout", got, 1);
    endtask

    task automatic release_reqs();
        @(posedge clk); #1;
        c_req = 0; a_req = 0;
    endtask

    task automatic rand_port(input bit aux);
        logic [AW-1:0] ad;
        ad = AW'($urandom_range(0, 1023));
        if ($urandom_range(0, 1) == 1) ad = ad & ~AW'(3);
        if ($urandom_range(0, 7) == 0) ad = AW'($urandom_range(990, 1023));
        if (aux) begin
            a_req = ($urandom_range(0, 3) != 0); a_we = 1'($urandom_range(0, 1));
            a_funct3 = 3'($urandom_range(0, 7)); a_addr = ad; a_wdata = $urandom;
        end else begin
            c_req = ($urandom_range(0, 3) != 0); c_we = 1'($urandom_range(0, 1));
            c_funct3 = 3'($urandom_range(0, 7)); c_addr = ad; c_wdata = $urandom;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic cg [5];
        logic ag [5];
        for (int i = 0; i < DEPTH; i++) begin
            phys_mem[i] = 8'($urandom);
            ref_mem[i]  = phys_mem[i];
        end
        phys_mem[8] = 8'h44; phys_mem[9] = 8'h33; phys_mem[10] = 8'h22; phys_mem[11] = 8'h11;
        for (int i = 8; i < 12; i++) ref_mem[i] = phys_mem[i];

        // Requests pending during reset must be ignored.
        c_req = 1; a_req = 1; a_funct3 = 3'b010;
        repeat (3) @(posedge clk);
        #1 reset = 0; c_req = 0; a_req = 0;
        @(negedge clk);
        chk("idle_outputs", any_out(), 0);

        // Core LW at 8.
        do_req(0, 0, 3'b010, 8, 0);
        chk("lw8_m_addr", m_addr, 8);
        chk("lw8_m_en", m_en, 1);
        release_reqs();
        @(negedge clk);
        chk("lw8_rvalid", c_rvalid, 1);
        chk("lw8_rdata", c_rdata, 32'h11223344);

        // Both requesting continuously: four core grants, then aux.
        @(posedge clk); #1;
        c_req = 1; c_we = 0; c_funct3 = 3'b010; c_addr = AW'(0);
        a_req = 1; a_we = 0; a_funct3 = 3'b100; a_addr = AW'(21);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cg[i] = c_gnt; ag[i] = a_gnt;
            if (i == 4) chk("starve_core_stall", core_stall, 1);
        end
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("starve_c_gnt_%0d", i), cg[i], (i < 4));
            chk($sformatf("starve_a_gnt_%0d", i), ag[i], (i == 4));
        end
        release_reqs();

        // Misaligned SH -> fault.
        do_req(0, 1, 3'b001, 3, 32'hdead);
        chk("sh3_m_en", m_en, 0);
        release_reqs();
        @(negedge clk);
        chk("sh3_rvalid", c_rvalid, 1);
        chk("sh3_err", c_err, 1);
        chk("sh3_rdata", c_rdata, 0);

        // Aux SW at the top boundary, then one byte past.
        do_req(1, 1, 3'b010, 996, 32'hcafef00d);
        chk("sw996_m_en", m_en, 1);
        chk("sw996_m_we", m_we, 1);
        release_reqs();
        @(negedge clk);
        chk("sw996_no_resp", a_rvalid, 0);
        do_req(1, 1, 3'b010, 997, 32'h1);
        release_reqs();
        @(negedge clk);
        chk("sw997_err", a_err, 1);

        // Reset right after a load grant drops the response.
        do_req(0, 0, 3'b000, 5, 0);
        @(posedge clk); #1 c_req = 0; reset = 1;
        @(negedge clk);
        chk("rst_mid_c_rvalid", c_rvalid, 0);
        chk("rst_mid_outputs", any_out(), 0);
        @(posedge clk); #1 reset = 0;

        // Random dual-port traffic; each requester holds until granted.
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            if (last_c_gnt || !c_req) rand_port(0);
            if (last_a_gnt || !a_req) rand_port(1);
        end
        @(posedge clk); #1 c_req = 0; a_req = 0;
        repeat (3) @(negedge clk);
        chk("c_queue_drained", cq.size(), 0);
        chk("a_queue_drained", aq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
